// File: rtl/sdram_rdata.sv
// SDRAM read-data return path: CAS-latency pipe, dq capture, tagged return FIFO.
// Latency: rd_issue in cycle 0 -> dq sampled end of cycle CL -> rdata_valid from cycle CL+2.
// Backpressure: FIFO drains on valid/ready; rd_credit gates new READs, overflow drops and sets sticky rd_ovf.
module sdram_rdata #(
   parameter int DW         = 16,
   parameter int TAGW       = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_CL     = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      cfg_cas_latency,
   input  logic            rd_issue,
   input  logic [TAGW-1:0] rd_tag,
   input  logic [DW-1:0]   sdram_dq,
   output logic            rdata_valid,
   output logic [DW-1:0]   rdata,
   output logic [TAGW-1:0] rdata_tag,
   input  logic            rdata_ready,
   output logic            rd_credit,
   output logic            rd_busy,
   output logic            rd_ovf
);

   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam int IFW = $clog2(MAX_CL + 2);

   // Latency pipe: index s holds stage s+1
   logic [MAX_CL-1:0] pipe_vld;
   logic [TAGW-1:0]   pipe_tag [MAX_CL];
   logic              cap_vld;
   logic [TAGW-1:0]   cap_tag;
   logic [DW-1:0]     dq_q;

   logic [DW+TAGW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      fifo_count;

   int                 cl_eff;
   logic               sel_vld;
   logic [TAGW-1:0]    sel_tag;
   logic [IFW-1:0]     inflight;
   logic               fifo_full;
   logic               pop;
   logic               push;

   // Clamp the CAS latency and select the pipe stage that feeds the capture flag
   always_comb begin
      cl_eff  = int'(cfg_cas_latency);
      sel_vld = 1'b0;
      sel_tag = '0;
      if (cl_eff == 0 || cl_eff > MAX_CL) cl_eff = MAX_CL;
      for (int s = 0; s < MAX_CL; s++) begin
         if (s + 1 == cl_eff) begin
            sel_vld = pipe_vld[s];
            sel_tag = pipe_tag[s];
         end
      end
   end

   // Shift the pipe; stage CL leaves into cap, stages beyond CL keep draining out the top
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
         for (int s = 0; s < MAX_CL; s++) pipe_tag[s] <= '0;
         cap_vld  <= 1'b0;
         cap_tag  <= '0;
      end else begin
         pipe_vld[0] <= rd_issue;
         pipe_tag[0] <= rd_tag;
         for (int s = 1; s < MAX_CL; s++) begin
            pipe_vld[s] <= (s == cl_eff) ? 1'b0 : pipe_vld[s-1];
            pipe_tag[s] <= pipe_tag[s-1];
         end
         cap_vld <= sel_vld;
         cap_tag <= sel_tag;
      end
   end

   // Register the SDRAM bus every cycle; cap marks the cycles that matter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) dq_q <= '0;
      else     dq_q <= sdram_dq;
   end

   // Count reads still travelling through the pipe or waiting in cap
   always_comb begin
      inflight = IFW'(cap_vld);
      for (int s = 0; s < MAX_CL; s++) inflight = inflight + IFW'(pipe_vld[s]);
   end

   assign fifo_full   = (fifo_count == CW'(FIFO_DEPTH));
   assign rdata_valid = (fifo_count != '0);
   assign pop         = rdata_valid & rdata_ready;
   // A pop on the same edge frees the slot, so a full FIFO can still accept
   assign push        = cap_vld & (~fifo_full | pop);

   // FIFO storage needs no reset; the empty mux hides stale contents
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {dq_q, cap_tag};
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         rd_ovf     <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (cap_vld & fifo_full & ~pop) rd_ovf <= 1'b1;
      end
   end

   assign {rdata, rdata_tag} = rdata_valid ? mem[rd_ptr] : '0;
   assign rd_credit = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
   assign rd_busy   = (inflight != '0) | (fifo_count != '0);

endmodule

// File: tb/tb_sdram_rdata.sv
// Bench for sdram_rdata: directed scenarios plus randomized traffic at several CAS latencies.
// Expected outputs come from a queue-based model of issued reads and the return FIFO.
// Inputs change #1 after the rising edge; outputs are compared before the next edge.
module tb_sdram_rdata;

   logic        clk;
   logic        rst;
   logic [2:0]  cfg_cas_latency;
   logic        rd_issue;
   logic [3:0]  rd_tag;
   logic [15:0] sdram_dq;
   logic        rdata_valid;
   logic [15:0] rdata;
   logic [3:0]  rdata_tag;
   logic        rdata_ready;
   logic        rd_credit;
   logic        rd_busy;
   logic        rd_ovf;

   int checks   = 0;
   int failures = 0;

   // Model state: queued words, reads issued but not yet captured, sticky overflow
   int mq_dat[$];
   int mq_tag[$];
   int pd_due[$];
   int pd_tag[$];
   bit m_ovf;
   int m_cl;
   int cyc_n;
   int prev_dq;

   sdram_rdata #(.DW(16), .TAGW(4), .FIFO_DEPTH(4), .MAX_CL(3)) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_cas_latency (cfg_cas_latency),
      .rd_issue        (rd_issue),
      .rd_tag          (rd_tag),
      .sdram_dq        (sdram_dq),
      .rdata_valid     (rdata_valid),
      .rdata           (rdata),
      .rdata_tag       (rdata_tag),
      .rdata_ready     (rdata_ready),
      .rd_credit       (rd_credit),
      .rd_busy         (rd_busy),
      .rd_ovf          (rd_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [31:0] ed;
      logic [31:0] et;
      ed = (mq_dat.size() > 0) ? 32'(mq_dat[0]) : 32'd0;
      et = (mq_tag.size() > 0) ? 32'(mq_tag[0]) : 32'd0;
      chk("rdata_valid", 32'(rdata_valid), 32'(mq_dat.size() > 0));
      chk("rdata",       32'(rdata),       ed);
      chk("rdata_tag",   32'(rdata_tag),   et);
      chk("rd_credit",   32'(rd_credit),   32'((mq_dat.size() + pd_due.size()) < 4));
      chk("rd_busy",     32'(rd_busy),     32'((mq_dat.size() + pd_due.size()) != 0));
      chk("rd_ovf",      32'(rd_ovf),      32'(m_ovf));
   endtask

   task automatic model_clear();
      mq_dat.delete();
      mq_tag.delete();
      pd_due.delete();
      pd_tag.delete();
      m_ovf = 1'b0;
   endtask

   // One clock cycle: drive inputs, compare against the model, take the edge, advance the model
   task automatic cyc(input bit iss, input int tg, input bit rdy, input int dqv);
      int d;
      int had;
      bit do_pop;
      d = (dqv < 0) ? int'($urandom_range(0, 65535)) : dqv;
      rd_issue    = iss;
      rd_tag      = 4'(tg);
      rdata_ready = rdy;
      sdram_dq    = 16'(d);
      check_model();
      @(posedge clk);
      had    = mq_dat.size();
      do_pop = rdy && (had > 0);
      if (do_pop) begin
         void'(mq_dat.pop_front());
         void'(mq_tag.pop_front());
      end
      // A read issued in cycle n samples dq of cycle n+CL and is written at the end of cycle n+CL+1
      if (pd_due.size() > 0 && pd_due[0] == cyc_n - 1) begin
         if (had == 4 && !do_pop) m_ovf = 1'b1;
         else begin
            mq_dat.push_back(prev_dq);
            mq_tag.push_back(pd_tag[0]);
         end
         void'(pd_due.pop_front());
         void'(pd_tag.pop_front());
      end
      if (iss) begin
         pd_due.push_back(cyc_n + m_cl);
         pd_tag.push_back(tg);
      end
      prev_dq = d;
      cyc_n++;
      #1;
   endtask

   task automatic set_cl(input int v);
      cfg_cas_latency = 3'(v);
      m_cl = (v == 0 || v > 3) ? 3 : v;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (mq_dat.size() + pd_due.size()) > 0; i++) cyc(0, 0, 1, -1);
      chk("drained_busy", 32'(rd_busy), 32'd0);
   endtask

   task automatic rand_traffic(input int n);
      bit iss;
      bit rdy;
      for (int i = 0; i < n; i++) begin
         iss = ((mq_dat.size() + pd_due.size()) < 4) && ($urandom_range(0, 2) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         cyc(iss, int'($urandom_range(0, 15)), rdy, -1);
      end
   endtask

   initial begin
      int cls[5];
      clk = 1'b0;
      rst = 1'b1;
      rd_issue = 1'b0;
      rd_tag = '0;
      sdram_dq = '0;
      rdata_ready = 1'b0;
      cyc_n = 0;
      prev_dq = 0;
      model_clear();
      set_cl(2);

      // Reset values
      #2;
      check_model();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // CL=2 single read, tag 5, dq 0xA5A5 in cycle 2
      cyc(1, 5, 1, -1);
      cyc(0, 0, 1, -1);
      cyc(0, 0, 1, 16'hA5A5);
      cyc(0, 0, 1, -1);
      chk("t1_valid_c4", 32'(rdata_valid), 32'd1);
      chk("t1_data_c4",  32'(rdata),       32'hA5A5);
      chk("t1_tag_c4",   32'(rdata_tag),   32'd5);
      cyc(0, 0, 1, -1);
      chk("t1_valid_c5", 32'(rdata_valid), 32'd0);
      drain();

      // CL=3 four back-to-back reads, dq 0x1000+tag in cycles 3..6, pops in cycles 5..8
      set_cl(3);
      for (int k = 0; k < 9; k++) begin
         cyc(k < 4, k, 1, (k >= 3 && k <= 6) ? 32'h1000 + k - 3 : -1);
         if (k + 1 >= 5 && k + 1 <= 8) begin
            chk("t2_valid", 32'(rdata_valid), 32'd1);
            chk("t2_data",  32'(rdata),       32'h1000 + k + 1 - 5);
         end
      end
      drain();

      // Credit exhaustion, forced overflow, credit return, full push+pop
      set_cl(2);
      for (int k = 0; k < 4; k++) cyc(1, k + 8, 0, -1);
      chk("credit_after4", 32'(rd_credit), 32'd0);
      for (int k = 0; k < 4; k++) cyc(0, 0, 0, -1);
      chk("ovf_clear", 32'(rd_ovf), 32'd0);
      cyc(1, 15, 0, -1);
      for (int k = 0; k < 4; k++) cyc(0, 0, 0, -1);
      chk("ovf_set",  32'(rd_ovf),    32'd1);
      chk("ovf_head", 32'(rdata_tag), 32'd8);
      cyc(0, 0, 1, -1);
      chk("credit_restored", 32'(rd_credit), 32'd1);
      cyc(1, 7, 0, -1);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, -1);
      chk("refilled_credit", 32'(rd_credit), 32'd0);
      cyc(1, 6, 0, -1);
      cyc(0, 0, 0, -1);
      cyc(0, 0, 0, -1);
      cyc(0, 0, 1, -1);
      chk("full_pushpop_credit", 32'(rd_credit),   32'd0);
      chk("full_pushpop_valid",  32'(rdata_valid), 32'd1);
      chk("ovf_sticky",          32'(rd_ovf),      32'd1);
      drain();

      // Asynchronous reset with two words queued and two in flight
      set_cl(3);
      for (int k = 0; k < 4; k++) cyc(1, k, 0, -1);
      cyc(0, 0, 0, -1);
      cyc(0, 0, 0, -1);
      chk("pre_rst_valid", 32'(rdata_valid), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      model_clear();
      check_model();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc_n++;
      for (int k = 0; k < 10; k++) cyc(0, 0, 1, -1);

      // Randomized traffic, including out-of-range CL settings
      cls[0] = 1; cls[1] = 2; cls[2] = 3; cls[3] = 0; cls[4] = 7;
      for (int p = 0; p < 5; p++) begin
         set_cl(cls[p]);
         rand_traffic(150);
         drain();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
